// File: rtl/mips_cpu.sv
// Single-cycle 32-bit MIPS subset CPU: PC, instruction ROM, register file, ALU, control, data RAM.
// One instruction retires per rising clk edge; all reads are combinational, all writes on the edge.

module pc_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next,
    output logic [31:0] OUT
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            OUT <= 32'h0;
        else
            OUT <= next;
    end
endmodule

module instr_mem #(
    parameter int IMEM_WORDS = 256
) (
    input  logic [31:0] addr,
    output logic [31:0] instr
);
    // Contents are placed here by the surrounding environment before reset is released.
    logic [31:0] InstructionMemory [0:IMEM_WORDS-1];
    logic [7:0]  word_idx;

    assign word_idx = addr[9:2];
    assign instr    = (int'(word_idx) < IMEM_WORDS) ? InstructionMemory[word_idx] : 32'h0;
endmodule

module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);
    logic [31:0] Registers [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                Registers[i] <= 32'h0;
        end else if (wr_en && (wr_addr != 5'd0)) begin
            Registers[wr_addr] <= wr_data;
        end
    end

    assign rs_data = (rs_addr == 5'd0) ? 32'h0 : Registers[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'h0 : Registers[rt_addr];
endmodule

module data_mem #(
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data
);
    logic [31:0] Memory [0:DMEM_WORDS-1];
    logic [7:0]  word_idx;
    logic        in_range;

    assign word_idx = addr[9:2];
    assign in_range = int'(word_idx) < DMEM_WORDS;
    assign rd_data  = in_range ? Memory[word_idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (wr_en && in_range)
            Memory[word_idx] <= wr_data;
    end
endmodule

module mips_cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] instr;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        mem_we;

    pc_reg ProgCounter (
        .clk  (clk),
        .rst  (reset),
        .next (next_pc),
        .OUT  (pc)
    );

    instr_mem #(.IMEM_WORDS(IMEM_WORDS)) IM (
        .addr  (pc),
        .instr (instr)
    );

    reg_file RF (
        .clk     (clk),
        .rst     (reset),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_val),
        .rt_data (rt_val),
        .wr_en   (reg_we),
        .wr_addr (reg_waddr),
        .wr_data (reg_wdata)
    );

    // Stores are gated by reset so an aborted instruction never reaches memory.
    data_mem #(.DMEM_WORDS(DMEM_WORDS)) DM (
        .clk     (clk),
        .addr    (mem_addr),
        .wr_en   (mem_we && !reset),
        .wr_data (rt_val),
        .rd_data (mem_rdata)
    );

    assign pc_out        = pc;
    assign pc_plus4      = pc + 32'd4;
    assign opcode        = instr[31:26];
    assign rs            = instr[25:21];
    assign rt            = instr[20:16];
    assign rd            = instr[15:11];
    assign shamt         = instr[10:6];
    assign funct         = instr[5:0];
    assign imm16         = instr[15:0];
    assign target        = instr[25:0];
    assign imm_sext      = {{16{imm16[15]}}, imm16};
    assign imm_zext      = {16'h0, imm16};
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], target, 2'b00};
    assign mem_addr      = rs_val + imm_sext;

    always_comb begin
        reg_we    = 1'b0;
        reg_waddr = rt;
        reg_wdata = 32'h0;
        mem_we    = 1'b0;
        next_pc   = pc_plus4;
        unique case (opcode)
            OP_RTYPE: begin
                reg_waddr = rd;
                reg_we    = 1'b1;
                case (funct)
                    6'h20, 6'h21: reg_wdata = rs_val + rt_val;
                    6'h22, 6'h23: reg_wdata = rs_val - rt_val;
                    6'h24:        reg_wdata = rs_val & rt_val;
                    6'h25:        reg_wdata = rs_val | rt_val;
                    6'h26:        reg_wdata = rs_val ^ rt_val;
                    6'h27:        reg_wdata = ~(rs_val | rt_val);
                    6'h2a:        reg_wdata = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    6'h2b:        reg_wdata = {31'h0, rs_val < rt_val};
                    6'h00:        reg_wdata = rt_val << shamt;
                    6'h02:        reg_wdata = rt_val >> shamt;
                    6'h03:        reg_wdata = $signed(rt_val) >>> shamt;
                    6'h04:        reg_wdata = rt_val << rs_val[4:0];
                    6'h06:        reg_wdata = rt_val >> rs_val[4:0];
                    6'h07:        reg_wdata = $signed(rt_val) >>> rs_val[4:0];
                    6'h08: begin
                        reg_we  = 1'b0;
                        next_pc = rs_val;
                    end
                    default:      reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                reg_we    = 1'b1;
                reg_wdata = rs_val + imm_sext;
            end
            OP_SLTI: begin
                reg_we    = 1'b1;
                reg_wdata = {31'h0, $signed(rs_val) < $signed(imm_sext)};
            end
            OP_SLTIU: begin
                reg_we    = 1'b1;
                reg_wdata = {31'h0, rs_val < imm_sext};
            end
            OP_ANDI: begin
                reg_we    = 1'b1;
                reg_wdata = rs_val & imm_zext;
            end
            OP_ORI: begin
                reg_we    = 1'b1;
                reg_wdata = rs_val | imm_zext;
            end
            OP_XORI: begin
                reg_we    = 1'b1;
                reg_wdata = rs_val ^ imm_zext;
            end
            OP_LUI: begin
                reg_we    = 1'b1;
                reg_wdata = {imm16, 16'h0};
            end
            OP_LW: begin
                reg_we    = 1'b1;
                reg_wdata = mem_rdata;
            end
            OP_SW:  mem_we = 1'b1;
            OP_BEQ: next_pc = (rs_val == rt_val) ? branch_target : pc_plus4;
            OP_BNE: next_pc = (rs_val != rt_val) ? branch_target : pc_plus4;
            OP_J:   next_pc = jump_target;
            OP_JAL: begin
                next_pc   = jump_target;
                reg_we    = 1'b1;
                reg_waddr = 5'd31;
                reg_wdata = pc_plus4;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: small hand-assembled programs loaded into the instruction ROM,
// architectural state compared against hand-computed values.

module tb_mips_cpu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_out;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] prog [$];

    mips_cpu #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk    (clk),
        .reset  (reset),
        .pc_out (pc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rf(input int n);
        return dut.RF.Registers[n];
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int tgt);
        return {6'(op), 26'(tgt)};
    endfunction

    // Holds reset, loads prog into the ROM (rest zero), releases reset on a falling edge.
    task automatic start_prog();
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++)
            dut.IM.InstructionMemory[i] = (i < prog.size()) ? prog[i] : 32'h0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pc(input logic [31:0] exp, input int bound, input string tag);
        for (int i = 0; i < bound && pc_out !== exp; i++)
            @(negedge clk);
        check(tag, pc_out, exp);
    endtask

    localparam logic [31:0] HALT = 32'h1000_FFFF;

    initial begin
        // ALU program
        prog = '{};
        prog.push_back(enc_i(8'h08, 0, 8, 100));
        prog.push_back(enc_i(8'h08, 0, 9, 7));
        prog.push_back(enc_r(8, 9, 10, 0, 8'h22));
        prog.push_back(enc_r(9, 8, 11, 0, 8'h2a));
        prog.push_back(enc_i(8'h08, 0, 12, -8));
        prog.push_back(enc_r(0, 12, 13, 2, 8'h03));
        prog.push_back(enc_r(0, 12, 14, 28, 8'h02));
        prog.push_back(enc_r(9, 12, 15, 0, 8'h2b));
        prog.push_back(enc_r(9, 12, 16, 0, 8'h2a));
        prog.push_back(enc_r(8, 0, 17, 0, 8'h27));
        prog.push_back(enc_r(9, 9, 18, 0, 8'h04));
        prog.push_back(enc_i(8'h0e, 8, 19, 16'hFFFF));
        prog.push_back(enc_i(8'h0c, 12, 20, 16'h00F0));
        prog.push_back(enc_i(8'h0a, 12, 21, 0));
        prog.push_back(enc_r(8, 9, 22, 0, 8'h25));
        prog.push_back(enc_r(8, 9, 23, 0, 8'h24));
        prog.push_back(enc_i(8'h0b, 9, 24, -1));
        prog.push_back(enc_r(9, 12, 25, 0, 8'h07));
        prog.push_back(enc_r(0, 9, 26, 4, 8'h00));
        prog.push_back(enc_r(8, 12, 27, 0, 8'h20));
        prog.push_back(HALT);
        start_prog();
        check("reset_pc", pc_out, 32'h0);
        run(30);
        check("addi_t0", rf(8), 32'h64);
        check("addi_t1", rf(9), 32'h07);
        check("sub_t2", rf(10), 32'h5D);
        check("slt_t3", rf(11), 32'h1);
        check("addi_neg", rf(12), 32'hFFFF_FFF8);
        check("sra", rf(13), 32'hFFFF_FFFE);
        check("srl", rf(14), 32'h0000_000F);
        check("sltu", rf(15), 32'h1);
        check("slt_neg", rf(16), 32'h0);
        check("nor", rf(17), 32'hFFFF_FF9B);
        check("sllv", rf(18), 32'h0000_0380);
        check("xori", rf(19), 32'h0000_FF9B);
        check("andi", rf(20), 32'h0000_00F0);
        check("slti", rf(21), 32'h1);
        check("or", rf(22), 32'h67);
        check("and", rf(23), 32'h4);
        check("sltiu", rf(24), 32'h1);
        check("srav", rf(25), 32'hFFFF_FFFF);
        check("sll", rf(26), 32'h70);
        check("add", rf(27), 32'h5C);
        check("alu_halt_pc", pc_out, 32'h50);

        // Empty ROM: every word is a NOP, registers cleared by reset
        prog = '{};
        start_prog();
        run(10);
        check("nop_pc", pc_out, 32'h28);
        check("nop_pc_mirror", dut.ProgCounter.OUT, 32'h28);
        for (int r = 0; r < 32; r++)
            check($sformatf("reg_zero_%0d", r), rf(r), 32'h0);

        // Division 100/7 by repeated subtraction
        prog = '{};
        prog.push_back(enc_i(8'h08, 0, 8, 100));
        prog.push_back(enc_i(8'h08, 0, 9, 7));
        prog.push_back(enc_i(8'h08, 0, 2, 0));
        prog.push_back(enc_r(8, 9, 10, 0, 8'h2a));
        prog.push_back(enc_i(8'h05, 10, 0, 3));
        prog.push_back(enc_r(8, 9, 8, 0, 8'h22));
        prog.push_back(enc_i(8'h08, 2, 2, 1));
        prog.push_back(enc_j(8'h02, 3));
        prog.push_back(enc_r(8, 0, 3, 0, 8'h20));
        prog.push_back(HALT);
        start_prog();
        wait_pc(32'h24, 500, "div_reach_halt");
        check("div_quot", rf(2), 32'h0E);
        check("div_rem", rf(3), 32'h02);
        run(3);
        check("div_halt_stays", pc_out, 32'h24);
        check("div_quot_stays", rf(2), 32'h0E);

        // Asynchronous reset in the middle of the loop, then rerun
        start_prog();
        run(30);
        #2 reset = 1'b1;
        #1;
        check("midreset_pc", pc_out, 32'h0);
        check("midreset_v0", rf(2), 32'h0);
        check("midreset_t0", rf(8), 32'h0);
        check("midreset_t1", rf(9), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_pc(32'h24, 500, "rerun_reach_halt");
        check("rerun_quot", rf(2), 32'h0E);
        check("rerun_rem", rf(3), 32'h02);
        check("rerun_t0", rf(8), 32'h02);

        // lui/ori, sw/lw, unknown opcode, jal/jr, write to $0
        prog = '{};
        prog.push_back(enc_i(8'h0f, 0, 8, 16'h1234));
        prog.push_back(enc_i(8'h0d, 8, 8, 16'h5678));
        prog.push_back(enc_i(8'h2b, 0, 8, 8));
        prog.push_back(enc_i(8'h08, 0, 16, 4));
        prog.push_back(enc_i(8'h23, 16, 17, 4));
        prog.push_back(enc_i(8'h23, 0, 9, 8));
        prog.push_back(enc_i(8'h3f, 0, 12, 1));
        prog.push_back(enc_j(8'h03, 10));
        prog.push_back(enc_i(8'h08, 0, 11, 1));
        prog.push_back(HALT);
        prog.push_back(enc_i(8'h08, 0, 10, 16'h55));
        prog.push_back(enc_i(8'h08, 0, 0, 5));
        prog.push_back(enc_r(31, 0, 0, 0, 8'h08));
        start_prog();
        run(20);
        check("lui_ori", rf(8), 32'h1234_5678);
        check("sw_mem", dut.DM.Memory[2], 32'h1234_5678);
        check("lw_zero_base", rf(9), 32'h1234_5678);
        check("lw_offset", rf(17), 32'h1234_5678);
        check("unknown_op_nowrite", rf(12), 32'h0);
        check("jal_ra", rf(31), 32'h20);
        check("sub_body", rf(10), 32'h55);
        check("zero_reg", rf(0), 32'h0);
        check("after_return", rf(11), 32'h1);
        check("call_halt_pc", pc_out, 32'h24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
